rtc_worktime: RTL and testbench
===============================

# rtc_worktime

Parametrised real-time clock and work-time accumulator for the appliance controller. Counts hours/minutes/seconds from an external tick enable with proper 60/60/HOUR_MOD wrap-around and validated field setting, and independently accumulates working time into whole hours with a threshold reminder. Sits between the tick divider and the display/mode controller.

## Interface
- TICKS_PER_SEC, 100: tick pulses per second; ≥2.
- HOUR_MOD, 24: hour wrap modulus; 2..60.
- WORK_LIMIT_H, 10: work_hours value at which remind asserts; 1..63.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- tick  in  1  single-cycle enable at TICKS_PER_SEC Hz.
- power_on  in  1  clock runs only while high.
- set_sel  in  2  00 run, 01 second, 10 minute, 11 hour field select.
- set_value  in  6  value to load into the selected field.
- set_strobe  in  1  single-cycle load request.
- state  in  2  appliance mode; 01 = working, 11 = cleaning, others idle.
- hour  out  6  0..HOUR_MOD-1.
- minute  out  6  0..59.
- second  out  6  0..59.
- sec_pulse  out  1  one-cycle pulse on every clock second advance.
- work_hours  out  6  completed work hours, saturating at 63.
- remind  out  1  high when work_hours ≥ WORK_LIMIT_H.
- set_err  out  1  one-cycle pulse on a rejected set.

## Operation
- Clock prescaler tcnt (width clog2(TICKS_PER_SEC)): advances on tick when power_on=1 and set_sel=00; at TICKS_PER_SEC-1 with tick → tcnt=0, sec_pulse=1, second advances.
- Carry chain resolved in the same cycle: second 59→0 carries into minute; minute 59→0 carries into hour; hour HOUR_MOD-1→0. No out-of-range value is ever visible.
- power_on=0 with set_sel=00: tcnt, hour, minute, second hold.
- set_sel≠00: clock frozen, tcnt forced to 0 (counting restarts with a full second on return to 00).
- set_strobe with set_sel=01/10: load second/minute if set_value ≤59; with 11: load hour if set_value < HOUR_MOD. Otherwise field unchanged, set_err=1 for one cycle. set_strobe with set_sel=00 ignored, no error.
- Work accumulator, independent of clock, power_on and set_sel: own prescaler wcnt (0..TICKS_PER_SEC-1) and wsec (12 bits, 0..3599) advance on tick while state=01. wsec 3599→0 increments work_hours; at 63 work_hours holds (wsec keeps wrapping).
- state=11: wcnt, wsec, work_hours cleared, remind cleared; takes priority over any accumulation that cycle.
- Other state values: accumulator holds.
- remind registered: set the cycle after work_hours becomes ≥ WORK_LIMIT_H; cleared only by state=11 or reset.

## Timing
- Reset (sync, highest priority): hour, minute, second, work_hours = 0; sec_pulse, remind, set_err = 0; all prescalers 0.
- All outputs registered. second/sec_pulse update on the clk edge sampling the terminal tick; no added latency.
- Set load and set_err visible one cycle after the set_strobe edge.
- work_hours increments on the edge sampling the 3600·TICKS_PER_SEC-th working tick; remind follows one cycle later.
- tick high for consecutive cycles counts once per cycle; ticks while reset high are discarded.

## Test plan
- TICKS_PER_SEC=4, set 23:59:59, run 4 ticks → 00:00:00, sec_pulse one cycle, no intermediate 60 or 24 visible.
- set_sel=10, set_value=60, strobe → minute unchanged, set_err pulse; set_value=45 → minute=45, no set_err.
- power_on=0 for 10 ticks mid-second → all fields and tcnt unchanged; power_on=1 resumes from same tcnt.
- TICKS_PER_SEC=2, WORK_LIMIT_H=2, state=01 for 14400 ticks → work_hours=2, remind high next cycle; state=11 one cycle → work_hours=0, remind=0.
- state=01 with set_sel=11 active → work_hours still accumulates while clock frozen.
- Reset asserted mid-count (clock 12:34:56, work_hours=5) → all outputs 0 on next edge; first tick after release starts from tcnt=0.

Source files
------------

// File: rtl/rtc_worktime.sv
// rtc_worktime: real-time clock (hh:mm:ss) driven by a tick enable, with
// validated field setting, plus an independent work-time accumulator.
//
// Ports:
//   clk        in   system clock, all state on the rising edge
//   reset      in   synchronous active-high reset, clears all state
//   tick       in   single-cycle enable at TICKS_PER_SEC Hz
//   power_on   in   clock advances only while high
//   set_sel    in   00 run, 01 second, 10 minute, 11 hour
//   set_value  in   value loaded into the selected field
//   set_strobe in   single-cycle load request
//   state      in   appliance mode, 01 working, 11 cleaning
//   hour       out  0..HOUR_MOD-1
//   minute     out  0..59
//   second     out  0..59
//   sec_pulse  out  one-cycle pulse per clock second advance
//   work_hours out  completed work hours, saturating at 63
//   remind     out  high once work_hours >= WORK_LIMIT_H
//   set_err    out  one-cycle pulse on a rejected set
module rtc_worktime #(
    parameter int TICKS_PER_SEC = 100,
    parameter int HOUR_MOD      = 24,
    parameter int WORK_LIMIT_H  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       power_on,
    input  logic [1:0] set_sel,
    input  logic [5:0] set_value,
    input  logic       set_strobe,
    input  logic [1:0] state,
    output logic [5:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       sec_pulse,
    output logic [5:0] work_hours,
    output logic       remind,
    output logic       set_err
);

    localparam int TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TW-1:0] TMAX     = TW'(TICKS_PER_SEC - 1);
    localparam logic [5:0]    HMAX     = 6'(HOUR_MOD - 1);
    localparam logic [5:0]    HMOD     = 6'(HOUR_MOD);
    localparam logic [5:0]    WLIM     = 6'(WORK_LIMIT_H);
    localparam logic [11:0]   WSEC_MAX = 12'd3599;

    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [5:0]    hour_q, hour_d;
    logic [5:0]    min_q, min_d;
    logic [5:0]    sec_q, sec_d;
    logic          pulse_q, pulse_d;
    logic          err_q, err_d;

    logic [TW-1:0] wcnt_q, wcnt_d;
    logic [11:0]   wsec_q, wsec_d;
    logic [5:0]    wh_q, wh_d;
    logic          remind_q, remind_d;

    // Clock: setting freezes the clock and restarts the prescaler so a
    // full second elapses after returning to run mode.
    always_comb begin
        tcnt_d  = tcnt_q;
        hour_d  = hour_q;
        min_d   = min_q;
        sec_d   = sec_q;
        pulse_d = 1'b0;
        err_d   = 1'b0;
        if (set_sel != 2'b00) begin
            tcnt_d = '0;
            if (set_strobe) begin
                case (set_sel)
                    2'b01: begin
                        if (set_value <= 6'd59) sec_d = set_value;
                        else err_d = 1'b1;
                    end
                    2'b10: begin
                        if (set_value <= 6'd59) min_d = set_value;
                        else err_d = 1'b1;
                    end
                    2'b11: begin
                        if (set_value < HMOD) hour_d = set_value;
                        else err_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end else if (power_on && tick) begin
            if (tcnt_q == TMAX) begin
                tcnt_d  = '0;
                pulse_d = 1'b1;
                // Whole carry chain resolves in one cycle.
                if (sec_q == 6'd59) begin
                    sec_d = 6'd0;
                    if (min_q == 6'd59) begin
                        min_d  = 6'd0;
                        hour_d = (hour_q == HMAX) ? 6'd0 : hour_q + 6'd1;
                    end else begin
                        min_d = min_q + 6'd1;
                    end
                end else begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
    end

    // Work accumulator: cleaning clears and wins over accumulation.
    always_comb begin
        wcnt_d   = wcnt_q;
        wsec_d   = wsec_q;
        wh_d     = wh_q;
        remind_d = remind_q | (wh_q >= WLIM);
        if (state == 2'b11) begin
            wcnt_d   = '0;
            wsec_d   = '0;
            wh_d     = '0;
            remind_d = 1'b0;
        end else if (state == 2'b01 && tick) begin
            if (wcnt_q == TMAX) begin
                wcnt_d = '0;
                if (wsec_q == WSEC_MAX) begin
                    wsec_d = '0;
                    if (wh_q != 6'd63) wh_d = wh_q + 6'd1;
                end else begin
                    wsec_d = wsec_q + 12'd1;
                end
            end else begin
                wcnt_d = wcnt_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tcnt_q   <= '0;
            hour_q   <= '0;
            min_q    <= '0;
            sec_q    <= '0;
            pulse_q  <= 1'b0;
            err_q    <= 1'b0;
            wcnt_q   <= '0;
            wsec_q   <= '0;
            wh_q     <= '0;
            remind_q <= 1'b0;
        end else begin
            tcnt_q   <= tcnt_d;
            hour_q   <= hour_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            pulse_q  <= pulse_d;
            err_q    <= err_d;
            wcnt_q   <= wcnt_d;
            wsec_q   <= wsec_d;
            wh_q     <= wh_d;
            remind_q <= remind_d;
        end
    end

    assign hour       = hour_q;
    assign minute     = min_q;
    assign second     = sec_q;
    assign sec_pulse  = pulse_q;
    assign work_hours = wh_q;
    assign remind     = remind_q;
    assign set_err    = err_q;

endmodule

// File: tb/tb_rtc_worktime.sv
// tb_rtc_worktime: directed and random stimulus against a time-of-day /
// total-work-ticks reference model, every output checked every cycle.
module tb_rtc_worktime;

    localparam int TPS = 2;
    localparam int HM  = 24;
    localparam int WL  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       power_on = 1'b1;
    logic [1:0] set_sel = 2'b00;
    logic [5:0] set_value = 6'd0;
    logic       set_strobe = 1'b0;
    logic [1:0] state = 2'b00;
    logic [5:0] hour, minute, second, work_hours;
    logic       sec_pulse, remind, set_err;

    int total = 0;
    int bad = 0;

    // Reference model: seconds-of-day plus a tick phase, and the raw
    // count of working ticks since the last clear.
    int     m_sub = 0;
    int     m_sod = 0;
    longint m_wt = 0;
    bit     m_pulse = 0;
    bit     m_err = 0;
    bit     m_rem = 0;

    rtc_worktime #(
        .TICKS_PER_SEC(TPS),
        .HOUR_MOD(HM),
        .WORK_LIMIT_H(WL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .power_on(power_on),
        .set_sel(set_sel),
        .set_value(set_value),
        .set_strobe(set_strobe),
        .state(state),
        .hour(hour),
        .minute(minute),
        .second(second),
        .sec_pulse(sec_pulse),
        .work_hours(work_hours),
        .remind(remind),
        .set_err(set_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int m_wh();
        longint h;
        h = m_wt / (3600 * TPS);
        return (h > 63) ? 63 : int'(h);
    endfunction

    task automatic model_edge();
        int h, m, s, v;
        if (reset) begin
            m_sub = 0; m_sod = 0; m_wt = 0;
            m_pulse = 0; m_err = 0; m_rem = 0;
            return;
        end
        m_pulse = 0;
        m_err = 0;
        m_rem = (state == 2'b11) ? 1'b0 : (m_rem || m_wh() >= WL);
        if (set_sel != 2'b00) begin
            m_sub = 0;
            if (set_strobe) begin
                h = m_sod / 3600;
                m = (m_sod / 60) % 60;
                s = m_sod % 60;
                v = int'(set_value);
                if (set_sel == 2'b01) begin
                    if (v < 60) s = v; else m_err = 1;
                end else if (set_sel == 2'b10) begin
                    if (v < 60) m = v; else m_err = 1;
                end else begin
                    if (v < HM) h = v; else m_err = 1;
                end
                m_sod = h * 3600 + m * 60 + s;
            end
        end else if (power_on && tick) begin
            m_sub++;
            if (m_sub == TPS) begin
                m_sub = 0;
                m_pulse = 1;
                m_sod = (m_sod + 1) % (HM * 3600);
            end
        end
        if (state == 2'b11) m_wt = 0;
        else if (state == 2'b01 && tick) m_wt++;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("hour", int'(hour), m_sod / 3600);
        chk("minute", int'(minute), (m_sod / 60) % 60);
        chk("second", int'(second), m_sod % 60);
        chk("sec_pulse", int'(sec_pulse), int'(m_pulse));
        chk("set_err", int'(set_err), int'(m_err));
        chk("work_hours", int'(work_hours), m_wh());
        chk("remind", int'(remind), int'(m_rem));
    endtask

    task automatic set_field(input logic [1:0] sel, input int v);
        set_sel = sel;
        set_value = 6'(v);
        set_strobe = 1'b1;
        step();
        set_strobe = 1'b0;
    endtask

    initial begin
        int r;
        // Reset state, with a tick present that must be discarded.
        reset = 1'b1;
        tick = 1'b1;
        state = 2'b01;
        repeat (3) step();
        reset = 1'b0;
        tick = 1'b0;
        state = 2'b00;
        step();

        // 23:59:59 rolls to 00:00:00 on the terminal tick.
        set_field(2'b11, 23);
        set_field(2'b10, 59);
        set_field(2'b01, 59);
        set_sel = 2'b00;
        step();
        tick = 1'b1;
        repeat (TPS) step();
        tick = 1'b0;
        step();
        chk("wrap_hour", int'(hour), 0);

        // Rejected and accepted minute loads, and bad hour / second.
        set_field(2'b10, 60);
        set_field(2'b10, 45);
        set_field(2'b11, HM);
        set_field(2'b11, HM - 1);
        set_field(2'b01, 63);
        set_sel = 2'b00;
        set_strobe = 1'b1;
        set_value = 6'd63;
        step();
        set_strobe = 1'b0;

        // Power off mid-second holds everything, then resumes.
        tick = 1'b1;
        step();
        power_on = 1'b0;
        repeat (10) step();
        power_on = 1'b1;
        repeat (2 * TPS + 1) step();
        tick = 1'b0;

        // Random mix of all controls.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom % 600) == 0;
            tick = ($urandom % 3) != 0;
            power_on = ($urandom % 8) != 0;
            set_sel = (($urandom % 10) == 0) ? 2'($urandom % 4) : 2'b00;
            set_strobe = $urandom % 2;
            set_value = 6'($urandom % 64);
            r = $urandom % 16;
            state = (r == 0) ? 2'b11 : (r <= 10) ? 2'b01 : 2'($urandom % 2 * 2);
            step();
        end
        reset = 1'b0;
        set_strobe = 1'b0;

        // Two work hours: first with clock running, then with clock frozen.
        state = 2'b11;
        set_sel = 2'b00;
        step();
        state = 2'b01;
        tick = 1'b1;
        for (int i = 0; i < 3600 * TPS; i++) begin
            power_on = ($urandom % 4) != 0;
            step();
        end
        set_sel = 2'b11;
        repeat (3600 * TPS) step();
        chk("wh_two", int'(work_hours), 2);
        state = 2'b00;
        step();
        chk("remind_set", int'(remind), 1);
        state = 2'b11;
        step();
        chk("clean_wh", int'(work_hours), 0);
        chk("clean_rem", int'(remind), 0);

        // Five work hours with clock frozen, then set 12:34:56 and reset.
        state = 2'b01;
        repeat (5 * 3600 * TPS) step();
        tick = 1'b0;
        state = 2'b00;
        set_field(2'b11, 12);
        set_field(2'b10, 34);
        set_field(2'b01, 56);
        set_sel = 2'b00;
        tick = 1'b1;
        step();
        chk("pre_rst_wh", int'(work_hours), 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (2 * TPS + 1) step();
        tick = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
